// File: rtl/eu_pkg.sv
// rtl/eu_pkg.sv - shared Execution Unit shifter op codes and sequencer state type
package eu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOVB = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/eu_shifter.sv
// rtl/eu_shifter.sv - single-position logical shifter / pass-through datapath
module eu_shifter
  import eu_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic [3:0]           op_select,
  input  logic [BUS_WIDTH-1:0] b,
  output logic [BUS_WIDTH-1:0] data_out
);

  // Decode the operation; unknown codes and NOP drive zero.
  always_comb begin
    data_out = '0;
    case (op_select)
      OP_MOVB: data_out = b;
      OP_SHR:  data_out = b >> 1;
      OP_SHL:  data_out = b << 1;
      default: data_out = '0;
    endcase
  end

endmodule

// File: rtl/eu_shift_seq.sv
// rtl/eu_shift_seq.sv - multi-cycle shift sequencer; optional rotate via EU_SHIFT_SEQ_ROTATE_EN
module eu_shift_seq
  import eu_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dir,
  input  logic                 rot,
  input  logic [CNT_WIDTH-1:0] amount,
  input  logic [BUS_WIDTH-1:0] operand,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] result
);

  state_t               state;
  state_t               next_state;
  logic                 dir_q;
  logic [CNT_WIDTH-1:0] amount_q;
  logic [BUS_WIDTH-1:0] b_reg;
  logic [BUS_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic [3:0]           op_select;
  logic [BUS_WIDTH-1:0] shifter_b;
  logic [BUS_WIDTH-1:0] data_out;
  logic [BUS_WIDTH-1:0] shift_next;

  eu_shifter #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_shifter (
    .op_select(op_select),
    .b        (shifter_b),
    .data_out (data_out)
  );

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state, shifter control and status outputs.
  always_comb begin
    next_state = state;
    op_select  = OP_NOP;
    shifter_b  = acc;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = LOAD;
      end
      LOAD: begin
        op_select  = OP_MOVB;
        shifter_b  = b_reg;
        next_state = (amount_q == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        op_select = dir_q ? OP_SHL : OP_SHR;
        if (cnt == CNT_WIDTH'(1)) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef EU_SHIFT_SEQ_ROTATE_EN
  logic rot_q;

  // Rotate request is captured alongside the other operation inputs.
  always_ff @(posedge clk) begin
    if (rst)                        rot_q <= 1'b0;
    else if (state == IDLE && start) rot_q <= rot;
  end

  // Patch the bit the shifter dropped back in at the vacated end.
  always_comb begin
    shift_next = data_out;
    if (rot_q) begin
      if (dir_q) shift_next = {data_out[BUS_WIDTH-1:1], acc[BUS_WIDTH-1]};
      else       shift_next = {acc[0], data_out[BUS_WIDTH-2:0]};
    end
  end
`else
  logic unused_rot;
  assign unused_rot = rot;

  // Without rotate support every step is a plain logical shift.
  always_comb begin
    shift_next = data_out;
  end
`endif

  // Operand latches, accumulator and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q    <= 1'b0;
      amount_q <= '0;
      b_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dir_q    <= dir;
            amount_q <= amount;
            b_reg    <= operand;
          end
        end
        LOAD: begin
          acc <= data_out;
          cnt <= amount_q;
        end
        SHIFT: begin
          acc <= shift_next;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = acc;

endmodule

// File: tb/tb_eu_shift_seq.sv
// tb/tb_eu_shift_seq.sv - scoreboard bench for eu_shift_seq with randomized traffic
module tb_eu_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dir;
  logic        rot;
  logic [3:0]  amount;
  logic [15:0] operand;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] res;
    int          at;
  } exp_t;

  exp_t sb[$];

  eu_shift_seq #(
    .BUS_WIDTH(16),
    .CNT_WIDTH(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .dir    (dir),
    .rot    (rot),
    .amount (amount),
    .operand(operand),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: shift or rotate by the whole amount in one arithmetic step.
  function automatic logic [15:0] model(input logic [15:0] op, input logic d,
                                        input logic r, input logic [3:0] a);
    logic unused_r;
    unused_r = r;
`ifdef EU_SHIFT_SEQ_ROTATE_EN
    if (r) return d ? ((op << a) | (op >> (16 - a))) : ((op >> a) | (op << (16 - a)));
`endif
    return d ? (op << a) : (op >> a);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(result), 32'hdead_beef);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic drive_start(input logic [15:0] op, input logic d, input logic r, input logic [3:0] a);
    start   = 1'b1;
    operand = op;
    dir     = d;
    rot     = r;
    amount  = a;
    @(posedge clk);
    #1;
    start   = 1'b0;
    operand = 16'($urandom);
    dir     = 1'($urandom);
    rot     = 1'($urandom);
    amount  = 4'($urandom);
  endtask

  task automatic run_op(input logic [15:0] op, input logic d, input logic r,
                        input logic [3:0] a, input logic [15:0] exp, output int busy_cycles);
    int t;
    busy_cycles = 0;
    @(negedge clk);
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    sb.push_back('{exp, cyc + int'(a) + 2});
    drive_start(op, d, r, a);
    t = 0;
    do begin
      @(negedge clk);
      if (busy) busy_cycles++;
      t++;
    end while (!done && t < 100);
    if (t >= 100) check("done_timeout", 32'(t), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int bc;
    logic [15:0] op;
    logic        d;
    logic        r;
    logic [3:0]  a;

    rst = 1'b1; start = 1'b0; dir = 1'b0; rot = 1'b0; amount = '0; operand = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_result", 32'(result), 32'(0));

    run_op(16'h1001, 1'b0, 1'b0, 4'd1, 16'h0800, bc);
    check("busy_cycles_amt1", 32'(bc), 32'(3));
    run_op(16'h0001, 1'b1, 1'b0, 4'd4, 16'h0010, bc);
    check("busy_cycles_amt4", 32'(bc), 32'(6));
    run_op(16'h0001, 1'b1, 1'b0, 4'd15, 16'h8000, bc);
    run_op(16'hface, 1'b0, 1'b0, 4'd0, 16'hface, bc);
    check("busy_cycles_amt0", 32'(bc), 32'(2));
    run_op(16'hcafe, 1'b0, 1'b0, 4'd15, 16'h0001, bc);

    // Start while busy must be ignored.
    fork
      run_op(16'h00ff, 1'b1, 1'b0, 4'd8, 16'hff00, bc);
      begin
        repeat (5) @(negedge clk);
        drive_start(16'h1234, 1'b0, 1'b0, 4'd3);
      end
    join
    repeat (3) @(negedge clk);
    check("no_extra_done", 32'(sb.size()), 32'(0));
    check("idle_after_ignored_start", 32'(busy), 32'(0));

    // Reset in the 4th SHIFT cycle discards the operation.
    @(negedge clk);
    drive_start(16'habcd, 1'b0, 1'b0, 4'd10);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_result", 32'(result), 32'(0));
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(sb.size()), 32'(0));
    run_op(16'h0001, 1'b1, 1'b0, 4'd2, 16'h0004, bc);

`ifdef EU_SHIFT_SEQ_ROTATE_EN
    run_op(16'h0001, 1'b0, 1'b1, 4'd1, 16'h8000, bc);
`else
    run_op(16'h0001, 1'b0, 1'b1, 4'd1, 16'h0000, bc);
`endif

    for (int i = 0; i < 40; i++) begin
      op = 16'($urandom);
      d  = 1'($urandom);
      r  = 1'($urandom);
      a  = 4'($urandom);
      run_op(op, d, r, a, model(op, d, r, a), bc);
      check("busy_cycles_rand", 32'(bc), 32'(int'(a) + 2));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
